// File: rtl/tap_read_arbiter.sv
// -----------------------------------------------------------------------------
// uart_pkg : address codes shared by the UART debug bridge.
//
// tap_read_arbiter : picks one read source and sends its data as a UART frame.
//   A source is either a host read from the UART command decoder or a
//   peripheral that has unsolicited data. Each frame is one header byte
//   {err, 2'b00, address} followed by the captured word, least significant
//   byte first.
//
// Ports
//   CLK_I            clock, rising edge
//   RST_I            asynchronous active-high reset
//   HOST_REQ_I       host read request (wins over VALID_ADDRESS_I)
//   HOST_ADDR_I      address of the host read
//   HOST_ACK_O       one-cycle pulse when the host request is accepted
//   VALID_ADDRESS_I  peripheral with unsolicited data, ADDR_NOP = none
//   READ_ADDRESS_O   address presented to the read interconnect
//   READ_READY_O     ready to the read interconnect
//   READ_VALID_I     valid from the read interconnect
//   READ_DATA_I      read word from the read interconnect
//   TX_DATA_O        byte to the UART transmitter
//   TX_VALID_O       TX byte valid
//   TX_READY_I       UART transmitter accepts the byte
//   BUSY_O           high whenever a frame is in progress
// -----------------------------------------------------------------------------
package uart_pkg;
  localparam int IRLENGTH = 5;
  localparam logic [IRLENGTH-1:0] ADDR_NOP     = 5'h00;
  localparam logic [IRLENGTH-1:0] ADDR_IDCODE  = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h02;
  localparam logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h03;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h04;
  localparam logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h05;
  localparam logic [IRLENGTH-1:0] ADDR_DTMCS   = 5'h10;
  localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;
endpackage

module tap_read_arbiter
  import uart_pkg::*;
#(
  parameter int READ_WIDTH     = 41,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  HOST_REQ_I,
  input  logic [IRLENGTH-1:0]   HOST_ADDR_I,
  output logic                  HOST_ACK_O,
  input  logic [IRLENGTH-1:0]   VALID_ADDRESS_I,
  output logic [IRLENGTH-1:0]   READ_ADDRESS_O,
  output logic                  READ_READY_O,
  input  logic                  READ_VALID_I,
  input  logic [READ_WIDTH-1:0] READ_DATA_I,
  output logic [7:0]            TX_DATA_O,
  output logic                  TX_VALID_O,
  input  logic                  TX_READY_I,
  output logic                  BUSY_O
);

  // The shift register holds at least six bytes so a DMI word always leaves
  // zeros in the unused top bits of its last byte.
  localparam int SHIFT_W = (READ_WIDTH > 48) ? ((READ_WIDTH + 7) / 8) * 8 : 48;
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BYTES_W = $clog2(SHIFT_W / 8 + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_DATA
  } state_t;

  state_t               state_reg, state_next;
  logic [IRLENGTH-1:0]  addr_reg, addr_next;
  logic [SHIFT_W-1:0]   shift_reg, shift_next;
  logic [BYTES_W-1:0]   count_reg, count_next;
  logic [CNT_W-1:0]     timer_reg, timer_next;
  logic                 err_reg, err_next;
  logic                 ack_reg, ack_next;
  logic [BYTES_W-1:0]   load_count;

  // Number of payload bytes for the latched address.
  always_comb begin
    load_count = BYTES_W'(4);
    if (addr_reg == ADDR_DMI) begin
      load_count = BYTES_W'(6);
    end else if ((addr_reg == ADDR_STB0_CS) || (addr_reg == ADDR_STB1_CS)) begin
      load_count = BYTES_W'(1);
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_reg <= ST_IDLE;
      addr_reg  <= ADDR_NOP;
      shift_reg <= '0;
      count_reg <= '0;
      timer_reg <= '0;
      err_reg   <= 1'b0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      shift_reg <= shift_next;
      count_reg <= count_next;
      timer_reg <= timer_next;
      err_reg   <= err_next;
      ack_reg   <= ack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    shift_next = shift_reg;
    count_next = count_reg;
    timer_next = timer_reg;
    err_next   = err_reg;
    ack_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Host read has priority; a peripheral still waiting is picked up on
        // the next IDLE cycle because it keeps VALID_ADDRESS_I asserted.
        if (HOST_REQ_I) begin
          addr_next  = HOST_ADDR_I;
          ack_next   = 1'b1;
          timer_next = '0;
          err_next   = 1'b0;
          state_next = ST_REQ;
        end else if (VALID_ADDRESS_I != ADDR_NOP) begin
          addr_next  = VALID_ADDRESS_I;
          timer_next = '0;
          err_next   = 1'b0;
          state_next = ST_REQ;
        end
      end

      ST_REQ: begin
        // READ_READY_O is high throughout REQ, so READ_VALID_I alone marks
        // the transfer edge. A transfer on the last allowed cycle still wins.
        if (READ_VALID_I) begin
          shift_next = SHIFT_W'(READ_DATA_I);
          count_next = load_count;
          state_next = ST_HDR;
        end else if (timer_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_next   = 1'b1;
          shift_next = '0;
          count_next = load_count;
          state_next = ST_HDR;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      ST_HDR: begin
        if (TX_READY_I) begin
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        if (TX_READY_I) begin
          shift_next = shift_reg >> 8;
          count_next = count_reg - 1'b1;
          if (count_reg == BYTES_W'(1)) begin
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from state and registers only, so TX_DATA_O cannot
  // move while a byte is stalled.
  assign HOST_ACK_O     = ack_reg;
  assign READ_READY_O   = (state_reg == ST_REQ);
  assign READ_ADDRESS_O = (state_reg == ST_REQ) ? addr_reg : ADDR_NOP;
  assign TX_VALID_O     = (state_reg == ST_HDR) || (state_reg == ST_DATA);
  assign BUSY_O         = (state_reg != ST_IDLE);

  always_comb begin
    TX_DATA_O = 8'h00;
    if (state_reg == ST_HDR) begin
      TX_DATA_O = {err_reg, 2'b00, addr_reg[4:0]};
    end else if (state_reg == ST_DATA) begin
      TX_DATA_O = shift_reg[7:0];
    end
  end

endmodule

// File: tb/tb_tap_read_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for tap_read_arbiter: table of frames with hand-derived header,
// length and last byte, hand-written sequences for arbitration priority and
// reset mid-frame, then random frames checked against a frame-level model.
// -----------------------------------------------------------------------------
module tb_tap_read_arbiter;
  import uart_pkg::*;

  localparam int RW = 41;
  localparam int TO = 255;

  logic          CLK_I = 1'b0;
  logic          RST_I;
  logic          HOST_REQ_I;
  logic [4:0]    HOST_ADDR_I;
  logic          HOST_ACK_O;
  logic [4:0]    VALID_ADDRESS_I;
  logic [4:0]    READ_ADDRESS_O;
  logic          READ_READY_O;
  logic          READ_VALID_I;
  logic [RW-1:0] READ_DATA_I;
  logic [7:0]    TX_DATA_O;
  logic          TX_VALID_O;
  logic          TX_READY_I;
  logic          BUSY_O;

  tap_read_arbiter #(.READ_WIDTH(RW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .HOST_REQ_I(HOST_REQ_I), .HOST_ADDR_I(HOST_ADDR_I), .HOST_ACK_O(HOST_ACK_O),
    .VALID_ADDRESS_I(VALID_ADDRESS_I),
    .READ_ADDRESS_O(READ_ADDRESS_O), .READ_READY_O(READ_READY_O),
    .READ_VALID_I(READ_VALID_I), .READ_DATA_I(READ_DATA_I),
    .TX_DATA_O(TX_DATA_O), .TX_VALID_O(TX_VALID_O), .TX_READY_I(TX_READY_I),
    .BUSY_O(BUSY_O)
  );

  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor: collects bytes, counts pulses, checks stalls ----
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ack_cnt = 0;
  int         rdy_cnt = 0;
  bit         hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always @(negedge CLK_I) begin
    if (RST_I) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("tx_hold_valid", 64'(TX_VALID_O), 64'd1);
        chk("tx_hold_data", 64'(TX_DATA_O), 64'(data_prev));
      end
      if (TX_VALID_O && TX_READY_I) got_q.push_back(TX_DATA_O);
      if (HOST_ACK_O) ack_cnt++;
      if (READ_READY_O) rdy_cnt++;
      hold_prev = TX_VALID_O && !TX_READY_I;
      data_prev = TX_DATA_O;
    end
  end

  // ---------------- frame-level reference model ------------------------------
  function automatic int nbytes(input logic [4:0] a);
    if (a == ADDR_DMI) return 6;
    if ((a == ADDR_STB0_CS) || (a == ADDR_STB1_CS)) return 1;
    return 4;
  endfunction

  task automatic build_exp(input logic [4:0] a, input logic [RW-1:0] d, input bit to);
    logic [47:0] word;
    exp_q.delete();
    exp_q.push_back({to, 2'b00, a});
    word = to ? 48'h0 : 48'(d);
    for (int i = 0; i < nbytes(a); i++) exp_q.push_back(word[8*i +: 8]);
  endtask

  // ---------------- one complete frame --------------------------------------
  // delay < 0 means the interconnect never answers (timeout).
  task automatic run_frame(input bit host, input logic [4:0] addr, input logic [RW-1:0] data,
                           input int delay, input bit rdy_rand, input bit keep_valid);
    int  k;
    bit  done;
    bit  xfer;
    bit  to;
    to = (delay < 0);
    build_exp(addr, data, to);
    chk("idle_before_frame", 64'(BUSY_O), 64'd0);
    got_q.delete();
    ack_cnt = 0;
    rdy_cnt = 0;
    if (host) begin
      HOST_REQ_I  = 1'b1;
      HOST_ADDR_I = addr;
    end else begin
      VALID_ADDRESS_I = addr;
    end
    @(posedge CLK_I); #1;
    HOST_REQ_I = 1'b0;
    if (!keep_valid) VALID_ADDRESS_I = ADDR_NOP;
    chk("ready_latency", 64'(READ_READY_O), 64'd1);
    chk("read_address", 64'(READ_ADDRESS_O), 64'(addr));
    k = 0;
    done = 1'b0;
    while (!done && k < TO + 10) begin
      READ_VALID_I = (delay >= 0) && (k >= delay);
      READ_DATA_I  = data;
      xfer = READ_READY_O && READ_VALID_I;
      @(posedge CLK_I); #1;
      k++;
      if (xfer || !READ_READY_O) done = 1'b1;
    end
    READ_VALID_I = 1'b0;
    chk("ready_dropped", 64'(READ_READY_O), 64'd0);
    k = 0;
    while (BUSY_O && k < 4000) begin
      TX_READY_I = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge CLK_I); #1;
      k++;
    end
    TX_READY_I = 1'b0;
    chk("frame_end_idle", 64'(BUSY_O), 64'd0);
    chk("host_ack_pulses", 64'(ack_cnt), host ? 64'd1 : 64'd0);
    chk("ready_cycles", 64'(rdy_cnt), to ? 64'(TO) : 64'(delay + 1));
    chk("frame_len", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("frame_byte", 64'(got_q[i]), 64'(exp_q[i]));
    $display("frame addr=%02h host=%0d timeout=%0d bytes=%0d", addr, host, to, got_q.size());
  endtask

  typedef struct {
    bit            host;
    logic [4:0]    addr;
    logic [RW-1:0] data;
    int            delay;
    bit            rdy_rand;
    logic [7:0]    exp_hdr;
    int            exp_n;
    logic [7:0]    exp_last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int k;
    logic [63:0] rnd;
    logic [4:0]  ra;
    int          rd;

    vecs[0] = '{1'b0, ADDR_STB0_CS, 41'hA5,           0, 1'b0, 8'h02, 1, 8'hA5};
    vecs[1] = '{1'b1, ADDR_DMI,     41'h1_2345_6789_AB, 2, 1'b0, 8'h11, 6, 8'h01};
    vecs[2] = '{1'b0, ADDR_STB1_D,  41'h1234,        -1, 1'b0, 8'h85, 4, 8'h00};
    vecs[3] = '{1'b1, ADDR_DMI,     41'h1_2345_6789_AB, 0, 1'b1, 8'h11, 6, 8'h01};
    vecs[4] = '{1'b1, ADDR_IDCODE,  41'h0_DEAD_BEEF,  1, 1'b0, 8'h01, 4, 8'hDE};
    vecs[5] = '{1'b0, ADDR_DTMCS,   41'h1FF_FFFF_FFFF, 3, 1'b1, 8'h10, 4, 8'hFF};
    vecs[6] = '{1'b0, ADDR_DMI,     41'h1FF_FFFF_FFFF, 0, 1'b0, 8'h11, 6, 8'h01};
    vecs[7] = '{1'b1, ADDR_STB1_CS, 41'h3C,           0, 1'b0, 8'h04, 1, 8'h3C};
    vecs[8] = '{1'b0, ADDR_STB0_D,  41'h0_0102_0304,  1, 1'b0, 8'h03, 4, 8'h01};

    RST_I = 1'b1;
    HOST_REQ_I = 1'b0;
    HOST_ADDR_I = ADDR_NOP;
    VALID_ADDRESS_I = ADDR_NOP;
    READ_VALID_I = 1'b0;
    READ_DATA_I = '0;
    TX_READY_I = 1'b0;

    // Reset state
    #3;
    chk("rst_busy", 64'(BUSY_O), 64'd0);
    chk("rst_ready", 64'(READ_READY_O), 64'd0);
    chk("rst_addr", 64'(READ_ADDRESS_O), 64'(ADDR_NOP));
    chk("rst_tx_valid", 64'(TX_VALID_O), 64'd0);
    chk("rst_tx_data", 64'(TX_DATA_O), 64'd0);
    chk("rst_ack", 64'(HOST_ACK_O), 64'd0);
    @(posedge CLK_I); @(posedge CLK_I); #1;
    RST_I = 1'b0;
    @(posedge CLK_I); #1;

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].host, vecs[v].addr, vecs[v].data, vecs[v].delay, vecs[v].rdy_rand, 1'b0);
      chk("tbl_len", 64'(got_q.size()), 64'(vecs[v].exp_n + 1));
      if (got_q.size() > vecs[v].exp_n) begin
        chk("tbl_hdr", 64'(got_q[0]), 64'(vecs[v].exp_hdr));
        chk("tbl_last", 64'(got_q[vecs[v].exp_n]), 64'(vecs[v].exp_last));
      end
    end

    // Host and peripheral in the same cycle: IDCODE first, then DMI re-arbitrated
    VALID_ADDRESS_I = ADDR_DMI;
    run_frame(1'b1, ADDR_IDCODE, 41'h0_1357_9BDF, 0, 1'b0, 1'b1);
    chk("prio_first_hdr", 64'(got_q[0]), 64'h01);
    run_frame(1'b0, ADDR_DMI, 41'h0_0A0B_0C0D_0E, 1, 1'b0, 1'b0);
    chk("prio_second_hdr", 64'(got_q[0]), 64'h11);

    // Reset during the third DMI data byte
    got_q.delete();
    HOST_REQ_I = 1'b1;
    HOST_ADDR_I = ADDR_DMI;
    @(posedge CLK_I); #1;
    HOST_REQ_I = 1'b0;
    READ_VALID_I = 1'b1;
    READ_DATA_I = 41'h1_2345_6789_AB;
    @(posedge CLK_I); #1;
    READ_VALID_I = 1'b0;
    TX_READY_I = 1'b1;
    k = 0;
    while (got_q.size() < 3 && k < 50) begin
      @(posedge CLK_I); #1;
      k++;
    end
    TX_READY_I = 1'b0;
    chk("third_byte_presented", 64'(TX_DATA_O), 64'h67);
    #2;
    RST_I = 1'b1;
    #1;
    chk("mid_rst_tx_valid", 64'(TX_VALID_O), 64'd0);
    chk("mid_rst_tx_data", 64'(TX_DATA_O), 64'd0);
    chk("mid_rst_busy", 64'(BUSY_O), 64'd0);
    chk("mid_rst_ready", 64'(READ_READY_O), 64'd0);
    chk("mid_rst_addr", 64'(READ_ADDRESS_O), 64'(ADDR_NOP));
    chk("mid_rst_ack", 64'(HOST_ACK_O), 64'd0);
    @(posedge CLK_I); @(posedge CLK_I); #1;
    RST_I = 1'b0;
    TX_READY_I = 1'b1;
    repeat (4) @(posedge CLK_I);
    #1;
    TX_READY_I = 1'b0;
    chk("no_bytes_after_rst", 64'(got_q.size()), 64'd3);
    chk("idle_after_rst", 64'(BUSY_O), 64'd0);
    $display("reset mid-frame bytes_before_reset=%0d", got_q.size());
    run_frame(1'b1, ADDR_DMI, 41'h1_2345_6789_AB, 0, 1'b0, 1'b0);

    // Random frames against the model
    for (int n = 0; n < 20; n++) begin
      rnd = {$urandom(), $urandom()};
      ra  = 5'($urandom_range(1, 31));
      rd  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      run_frame(1'($urandom_range(0, 1)), ra, rnd[RW-1:0], rd, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_read_arbiter.md
TAP_READ_ARBITER -- requirements
Module: tap_read_arbiter

Interface
REQ-001 Parameter READ_WIDTH, default 41, SHALL set the width of read data from the read interconnect (the DMI word).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum number of cycles to wait for READ_VALID_I before aborting.
REQ-003 IRLENGTH and the address codes (ADDR_NOP, ADDR_DMI, ADDR_STB0_CS, ADDR_STB0_D, ADDR_STB1_CS, ADDR_STB1_D, ADDR_IDCODE, ADDR_DTMCS) SHALL come from uart_pkg; IRLENGTH = 5.
REQ-004 Port: CLK_I  in  1  the single clock; all logic is on its rising edge.
REQ-005 Port: RST_I  in  1  reset, asynchronous and active-high.
REQ-006 Port: HOST_REQ_I  in  1  host-initiated read request from the UART command decoder.
REQ-007 Port: HOST_ADDR_I  in  IRLENGTH  address for the host read.
REQ-008 Port: HOST_ACK_O  out  1  one-cycle pulse when the host request is accepted.
REQ-009 Port: VALID_ADDRESS_I  in  IRLENGTH  address of a peripheral with unsolicited data; ADDR_NOP means none.
REQ-010 Port: READ_ADDRESS_O  out  IRLENGTH  address selected at the read interconnect.
REQ-011 Port: READ_READY_O  out  1  ready to the read interconnect.
REQ-012 Port: READ_VALID_I  in  1  valid from the read interconnect.
REQ-013 Port: READ_DATA_I  in  READ_WIDTH  data from the read interconnect.
REQ-014 Port: TX_DATA_O  out  8  byte to the UART transmitter.
REQ-015 Port: TX_VALID_O  out  1  TX byte valid.
REQ-016 Port: TX_READY_I  in  1  UART transmitter accepts the byte.
REQ-017 Port: BUSY_O  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have four states, IDLE, REQ, HDR and DATA; every output SHALL be registered or decoded from state and registers only.
REQ-019 In IDLE: READ_READY_O=0, READ_ADDRESS_O=ADDR_NOP, TX_VALID_O=0.
REQ-020 IDLE with HOST_REQ_I=1: latch HOST_ADDR_I, pulse HOST_ACK_O for exactly one cycle, move to REQ next cycle.
REQ-021 IDLE with HOST_REQ_I=0 and VALID_ADDRESS_I!=ADDR_NOP: latch VALID_ADDRESS_I, move to REQ.
REQ-022 If both events occur in the same cycle, the host request SHALL win; VALID_ADDRESS_I SHALL be ignored outside IDLE.
REQ-023 In REQ: READ_ADDRESS_O = latched address and READ_READY_O=1, starting the cycle after the IDLE decision.
REQ-024 A transfer happens on a rising edge with READ_READY_O=1 and READ_VALID_I=1: capture READ_DATA_I into the shift register, load the byte count, move to HDR, and drop READ_READY_O in the next cycle.
REQ-025 The timeout counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-026 If the counter reaches TIMEOUT_CYCLES with no transfer: set the error flag, load the shift register with zero, move to HDR.
REQ-027 Header byte in HDR: TX_DATA_O = {err, 2'b00, address[4:0]}.
REQ-028 TX_VALID_O SHALL stay at 1 until TX_READY_I=1.
REQ-029 On the header handshake, move to DATA.
REQ-030 In DATA: TX_DATA_O = shift[7:0], TX_VALID_O=1.
REQ-031 Each DATA handshake: shift right by 8 and decrement the count; after the last byte, return to IDLE.
REQ-032 Byte count per address: ADDR_DMI 6; ADDR_STB0_CS and ADDR_STB1_CS 1; every other address 4.
REQ-033 Unused high bits in the last byte SHALL be zero (DMI bits 47:41).
REQ-034 TX_DATA_O SHALL be stable while TX_VALID_O=1 and TX_READY_I=0.
REQ-035 The FSM SHALL spend at least one cycle in IDLE between frames.
REQ-036 A peripheral that is still valid SHALL be re-arbitrated on its next IDLE cycle.
REQ-037 The error flag SHALL clear on entry to REQ.

Reset
REQ-038 While RST_I=1 (asserted asynchronously): state=IDLE, READ_ADDRESS_O=ADDR_NOP, READ_READY_O=0, TX_VALID_O=0, TX_DATA_O=0, HOST_ACK_O=0, BUSY_O=0; counters, shift register and error flag cleared.
REQ-039 Reset in any state SHALL abandon the frame with no further TX_VALID_O; after RST_I falls, the first request is handled normally.

Verification
REQ-040 VALID_ADDRESS_I=ADDR_STB0_CS, status 0xA5 valid, TX_READY_I=1 -> READ_READY_O high one cycle later; TX bytes {0,0,0,ADDR_STB0_CS}, then 0xA5; back to IDLE.
REQ-041 HOST_REQ_I with ADDR_DMI, READ_DATA_I=41'h1_2345_6789_AB -> HOST_ACK_O one pulse; TX header, then AB 89 67 45 23 01.
REQ-042 HOST_REQ_I(ADDR_IDCODE) and VALID_ADDRESS_I=ADDR_DMI in the same cycle -> IDCODE frame first (header + 4 bytes), then the DMI frame.
REQ-043 ADDR_STB1_D with READ_VALID_I held low -> after TIMEOUT_CYCLES, header 0x80|ADDR_STB1_D, then four 0x00 bytes.
REQ-044 TX_READY_I toggles 0/1 during a DMI frame -> exactly 7 bytes, each held stable while stalled, with none lost or duplicated.
REQ-045 RST_I pulse during the third DATA byte -> outputs at reset values immediately, no more TX bytes; the next request gives a complete frame.
